// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage core: register index width and the
// memory-wait FSM encoding used by the hazard/stall controller.
package core_pkg;
  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    TIMEOUT = 2'd2
  } state_t;
endpackage

// File: rtl/hazard_match.sv
// Combinational RAW match of the ID sources against in-flight EXE/MEM writers.
// Build option HAZARD_FORWARDING_EN limits the match to EXE load-use only.
module hazard_match
  import core_pkg::*;
(
  input  logic [REG_W-1:0] i_src1,
  input  logic [REG_W-1:0] i_src2,
  input  logic             i_two_src,
  input  logic [REG_W-1:0] i_exe_dest,
  input  logic             i_exe_wb_en,
  input  logic             i_exe_mem_r_en,
  input  logic [REG_W-1:0] i_mem_dest,
  input  logic             i_mem_wb_en,
  output logic             o_hz
);
  logic w_hit1;
  logic w_hit2;

`ifdef HAZARD_FORWARDING_EN
  // ALU and MEM results reach ID through the bypass network; only a load in EXE
  // is too late to forward.
  logic w_unused_mem;
  assign w_unused_mem = ^{i_mem_dest, i_mem_wb_en};
  assign w_hit1 = i_exe_mem_r_en & i_exe_wb_en & (i_exe_dest == i_src1);
  assign w_hit2 = i_exe_mem_r_en & i_exe_wb_en & (i_exe_dest == i_src2);
`else
  logic w_unused_ld;
  assign w_unused_ld = i_exe_mem_r_en;
  assign w_hit1 = (i_exe_wb_en & (i_exe_dest == i_src1)) |
                  (i_mem_wb_en & (i_mem_dest == i_src1));
  assign w_hit2 = (i_exe_wb_en & (i_exe_dest == i_src2)) |
                  (i_mem_wb_en & (i_mem_dest == i_src2));
`endif

  assign o_hz = w_hit1 | (i_two_src & w_hit2);
endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing: RAW stalls, branch flush, memory-wait freeze with watchdog.
// Optional macro HAZARD_FORWARDING_EN (see hazard_match) selects load-use-only stalls.
module hazard_stall_controller
  import core_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_valid,
  input  logic [REG_W-1:0] ID_src1,
  input  logic [REG_W-1:0] ID_src2,
  input  logic             ID_two_src,
  input  logic [REG_W-1:0] EXE_Dest,
  input  logic             EXE_WB_EN,
  input  logic             EXE_MEM_R_EN,
  input  logic [REG_W-1:0] MEM_Dest,
  input  logic             MEM_WB_EN,
  input  logic             MEM_req,
  input  logic             MEM_ready,
  input  logic             Branch_taken,
  output logic             Stall,
  output logic             Bubble,
  output logic             Flush,
  output logic             Freeze,
  output logic             Mem_timeout,
  output logic [CNT_W-1:0] Stall_cnt,
  output logic [1:0]       o_dbg_state
);
  localparam int WC_W = $clog2(MAX_WAIT + 1);
  localparam logic [WC_W-1:0]  WC_ONE  = WC_W'(1);
  localparam logic [WC_W-1:0]  WC_MAX  = WC_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state, w_next_state;
  logic [WC_W-1:0]  r_wait_cnt, w_next_wait_cnt;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_hz;
  logic             w_freeze;

  hazard_match u_match (
    .i_src1        (ID_src1),
    .i_src2        (ID_src2),
    .i_two_src     (ID_two_src),
    .i_exe_dest    (EXE_Dest),
    .i_exe_wb_en   (EXE_WB_EN),
    .i_exe_mem_r_en(EXE_MEM_R_EN),
    .i_mem_dest    (MEM_Dest),
    .i_mem_wb_en   (MEM_WB_EN),
    .o_hz          (w_hz)
  );

  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    case (r_state)
      RUN: begin
        if (MEM_req & ~MEM_ready) begin
          w_next_state    = WAIT;
          w_next_wait_cnt = WC_ONE;
        end
      end
      WAIT: begin
        if (MEM_ready)                 w_next_state    = RUN;
        else if (r_wait_cnt == WC_MAX) w_next_state    = TIMEOUT;
        else                           w_next_wait_cnt = r_wait_cnt + WC_ONE;
      end
      TIMEOUT: ;
      default: w_next_state = RUN;
    endcase
  end

  // The ready cycle itself is not frozen; TIMEOUT freezes until reset.
  assign w_freeze = (MEM_req & ~MEM_ready) | (r_state == TIMEOUT);

  always_comb begin
    Stall  = 1'b0;
    Bubble = 1'b0;
    Flush  = 1'b0;
    Freeze = 1'b0;
    if (!rst) begin
      Freeze = w_freeze;
      if (!w_freeze) begin
        if (Branch_taken) begin
          Flush = 1'b1;
        end else if (ID_valid & w_hz) begin
          Stall  = 1'b1;
          Bubble = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= '0;
    end else begin
      r_state       <= w_next_state;
      r_wait_cnt    <= w_next_wait_cnt;
      r_mem_timeout <= r_mem_timeout | (w_next_state == TIMEOUT);
      if ((Stall | Freeze) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign Mem_timeout = r_mem_timeout;
  assign Stall_cnt   = r_stall_cnt;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_hazard_stall_controller;
  localparam int MAXW    = 4;
  localparam int CW      = 5;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic ID_valid, ID_two_src, EXE_WB_EN, EXE_MEM_R_EN, MEM_WB_EN;
  logic MEM_req, MEM_ready, Branch_taken;
  logic [3:0] ID_src1, ID_src2, EXE_Dest, MEM_Dest;
  logic Stall, Bubble, Flush, Freeze, Mem_timeout;
  logic [CW-1:0] Stall_cnt;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // clock
  always #5 clk = ~clk;

  hazard_stall_controller #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ID_valid(ID_valid), .ID_src1(ID_src1), .ID_src2(ID_src2),
    .ID_two_src(ID_two_src), .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN),
    .EXE_MEM_R_EN(EXE_MEM_R_EN), .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN),
    .MEM_req(MEM_req), .MEM_ready(MEM_ready), .Branch_taken(Branch_taken),
    .Stall(Stall), .Bubble(Bubble), .Flush(Flush), .Freeze(Freeze),
    .Mem_timeout(Mem_timeout), .Stall_cnt(Stall_cnt), .o_dbg_state(dbg_state)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_wait = 0;   // cycles spent waiting on memory so far, 0 = not waiting
  bit m_to   = 0;
  int m_cnt  = 0;
  bit e_stall, e_bubble, e_flush, e_freeze, hz;
  bit hit1, hit2;

  always_comb begin
`ifdef HAZARD_FORWARDING_EN
    hit1 = EXE_MEM_R_EN && EXE_WB_EN && (EXE_Dest == ID_src1);
    hit2 = EXE_MEM_R_EN && EXE_WB_EN && (EXE_Dest == ID_src2);
`else
    hit1 = (EXE_WB_EN && EXE_Dest == ID_src1) || (MEM_WB_EN && MEM_Dest == ID_src1);
    hit2 = (EXE_WB_EN && EXE_Dest == ID_src2) || (MEM_WB_EN && MEM_Dest == ID_src2);
`endif
    hz = ID_valid && (hit1 || (ID_two_src && hit2));
    e_stall = 0; e_bubble = 0; e_flush = 0; e_freeze = 0;
    if (!rst) begin
      e_freeze = (MEM_req && !MEM_ready) || m_to;
      if (!e_freeze) begin
        if (Branch_taken) e_flush = 1;
        else if (hz) begin e_stall = 1; e_bubble = 1; end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_wait = 0; m_to = 0; m_cnt = 0;
    end else begin
      if ((e_stall || e_freeze) && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      if (!m_to) begin
        if (m_wait == 0) begin
          if (MEM_req && !MEM_ready) m_wait = 1;
        end else if (MEM_ready) m_wait = 0;
        else if (m_wait == MAXW) m_to = 1;
        else m_wait = m_wait + 1;
      end
    end
  end

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall",  int'(Stall),  int'(e_stall));
      check("bubble", int'(Bubble), int'(e_bubble));
      check("flush",  int'(Flush),  int'(e_flush));
      check("freeze", int'(Freeze), int'(e_freeze));
      check("mem_timeout", int'(Mem_timeout), int'(m_to));
      check("stall_cnt", int'(Stall_cnt), m_cnt);
      check("state", int'(dbg_state), m_to ? 2 : (m_wait != 0 ? 1 : 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    ID_valid = 0; ID_src1 = 0; ID_src2 = 0; ID_two_src = 0;
    EXE_Dest = 0; EXE_WB_EN = 0; EXE_MEM_R_EN = 0;
    MEM_Dest = 0; MEM_WB_EN = 0; MEM_req = 0; MEM_ready = 0; Branch_taken = 0;
  endtask

  task automatic load_use3();
    idle();
    ID_valid = 1; ID_src1 = 4'd3; EXE_Dest = 4'd3; EXE_WB_EN = 1; EXE_MEM_R_EN = 1;
  endtask

  initial begin
    rst = 1; idle();
    step(); step();
    chk_en = 1;
    settle();
    check("rst_stall", int'(Stall), 0);
    check("rst_freeze", int'(Freeze), 0);
    step(); rst = 0;
    settle();
    check("post_rst_cnt", int'(Stall_cnt), 0);
    check("post_rst_to", int'(Mem_timeout), 0);

    // load-use
    step(); load_use3();
    settle();
    check("lu_stall", int'(Stall), 1);
    check("lu_bubble", int'(Bubble), 1);
    step(); idle(); ID_valid = 1; ID_src1 = 4'd3;
    settle();
    check("lu_nop_stall", int'(Stall), 0);
    check("lu_cnt", int'(Stall_cnt), 1);

    // src2 gating
    step(); idle(); ID_valid = 1; ID_src2 = 4'd5; EXE_Dest = 4'd5;
    EXE_WB_EN = 1; EXE_MEM_R_EN = 1;
    settle();
    check("src2_gated", int'(Stall), 0);
    step(); ID_two_src = 1;
    settle();
    check("src2_used", int'(Stall), 1);

    // ALU result in MEM
    step(); idle(); ID_valid = 1; ID_src1 = 4'd7; MEM_Dest = 4'd7; MEM_WB_EN = 1;
    settle();
`ifdef HAZARD_FORWARDING_EN
    check("mem_fwd_stall", int'(Stall), 0);
`else
    check("mem_fwd_stall", int'(Stall), 1);
`endif

    // branch beats hazard
    step(); load_use3(); Branch_taken = 1;
    settle();
    check("br_flush", int'(Flush), 1);
    check("br_stall", int'(Stall), 0);
    check("br_bubble", int'(Bubble), 0);

    // memory wait of 3 cycles
    step(); idle(); rst = 1;
    step(); rst = 0;
    step(); MEM_req = 1; MEM_ready = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      settle();
      check("wait_freeze", int'(Freeze), 1);
    end
    step(); MEM_ready = 1;
    settle();
    check("ready_freeze", int'(Freeze), 0);
    step(); idle();
    settle();
    check("wait_cnt3", int'(Stall_cnt), 3);
    check("wait_run", int'(dbg_state), 0);

    // timeout
    step(); MEM_req = 1; MEM_ready = 0;
    for (int i = 0; i < 4; i++) step();
    settle();
    check("to_not_yet", int'(Mem_timeout), 0);
    step();
    settle();
    check("to_set", int'(Mem_timeout), 1);
    check("to_state", int'(dbg_state), 2);
    step(); MEM_req = 0;
    settle();
    check("to_freeze", int'(Freeze), 1);
    step(); rst = 1;
    settle();
    check("to_rst_freeze", int'(Freeze), 0);
    step(); rst = 0;
    settle();
    check("to_clr", int'(Mem_timeout), 0);
    check("to_cnt_clr", int'(Stall_cnt), 0);
    check("to_run", int'(dbg_state), 0);

    // saturation
    step(); load_use3();
    for (int i = 0; i < 40; i++) step();
    settle();
    check("sat_cnt", int'(Stall_cnt), CNT_MAX);
    check("sat_stall", int'(Stall), 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      rst          = ($urandom_range(0, 99) == 0);
      ID_valid     = ($urandom_range(0, 9) < 8);
      ID_src1      = 4'($urandom_range(0, 3));
      ID_src2      = 4'($urandom_range(0, 3));
      ID_two_src   = 1'($urandom_range(0, 1));
      EXE_Dest     = 4'($urandom_range(0, 3));
      EXE_WB_EN    = 1'($urandom_range(0, 1));
      EXE_MEM_R_EN = 1'($urandom_range(0, 1));
      MEM_Dest     = 4'($urandom_range(0, 3));
      MEM_WB_EN    = 1'($urandom_range(0, 1));
      MEM_req      = ($urandom_range(0, 9) < 3);
      MEM_ready    = ($urandom_range(0, 9) < 7);
      Branch_taken = ($urandom_range(0, 9) == 0);
    end
    step(); idle();
    settle();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
